// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder:
//               FSM state encoding, data width, default geometry/latency and
//               the word-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DATA_W          = 32;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_LATENCY     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Bits needed to index DEPTH_WORDS words (never less than one bit).
    function automatic int idx_width(input int depth_words);
        return (depth_words < 2) ? 1 : $clog2(depth_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port DEPTH_WORDS x 32 storage. Synchronous write and
//               registered read; the read register holds its value between
//               reads and can be loaded with zero for rejected accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic              i_rd_zero,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read register: updated only on a read, otherwise holds the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_rd) begin
            r_rdata <= i_rd_zero ? '0 : r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : CPU data-memory responder. Accepts one load/store at a time
//               through a req/ready handshake, performs the array access
//               after a fixed LATENCY and signals completion with a one-cycle
//               ack pulse.
//               Optional macro DMEM_MISALIGN_CHK_EN: flags accesses with
//               addr_i[1:0] != 0 on err_o at ack, suppressing the write and
//               returning zero read data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [31:0]       rdata_o,
    output logic              err_o
);

    localparam int c_idx_w = idx_width(DEPTH_WORDS);
    // Counter only has to hold LATENCY-2.
    localparam int c_cnt_w = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam bit c_lat1  = (LATENCY == 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_we;
    logic [DATA_W-1:0]    r_wdata;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_err;
    logic                 r_ready;
    logic                 r_ack;
    logic                 r_err_out;

    logic [c_idx_w-1:0]   w_req_idx;
    logic                 w_mis;
    logic                 w_unused_addr;
    logic                 w_idle;
    logic                 w_commit;
    logic                 w_acc_we;
    logic                 w_acc_err;
    logic [c_idx_w-1:0]   w_acc_idx;
    logic [DATA_W-1:0]    w_acc_wdata;
    logic                 w_arr_wr;
    logic                 w_arr_rd;

    // Upper address bits fall off here, so addresses wrap modulo the array.
    assign w_req_idx = addr_i[c_idx_w+1:2];

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_mis = |addr_i[1:0];
`else
    assign w_mis = 1'b0;
`endif

    // Only part of the byte address selects a word; the rest is don't-care.
    assign w_unused_addr = ^addr_i;

    assign w_idle = (r_state == IDLE);

    // The array is touched on the edge that enters ACK. With LATENCY=1 that
    // is the accept edge itself, so the operands come straight from the
    // request inputs instead of the latches.
    assign w_commit    = !rst_i && (((r_state == BUSY) && (r_cnt == '0)) ||
                                    (c_lat1 && w_idle && req_i));
    assign w_acc_we    = w_idle ? we_i      : r_we;
    assign w_acc_err   = w_idle ? w_mis     : r_err;
    assign w_acc_idx   = w_idle ? w_req_idx : r_idx;
    assign w_acc_wdata = w_idle ? wdata_i   : r_wdata;

    assign w_arr_wr = w_commit &&  w_acc_we && !w_acc_err;
    assign w_arr_rd = w_commit && !w_acc_we;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_idx_w)
    ) u_array (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_wr      (w_arr_wr),
        .i_rd      (w_arr_rd),
        .i_rd_zero (w_acc_err),
        .i_idx     (w_acc_idx),
        .i_wdata   (w_acc_wdata),
        .o_rdata   (rdata_o)
    );

    // Control FSM: accept in IDLE, count down in BUSY, pulse ack in ACK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ready   <= 1'b1;
            r_ack     <= 1'b0;
            r_err_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_wdata <= wdata_i;
                        r_idx   <= w_req_idx;
                        r_err   <= w_mis;
                        r_ready <= 1'b0;
                        if (c_lat1) begin
                            r_state   <= ACK;
                            r_ack     <= 1'b1;
                            r_err_out <= w_mis;
                        end else begin
                            r_cnt   <= c_cnt_w'(LATENCY - 2);
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state   <= ACK;
                        r_ack     <= 1'b1;
                        r_err_out <= r_err;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ACK: begin
                    r_state   <= IDLE;
                    r_ack     <= 1'b0;
                    r_err_out <= 1'b0;
                    r_ready   <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    r_ack     <= 1'b0;
                    r_err_out <= 1'b0;
                    r_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign ack_o   = r_ack;
    assign err_o   = r_err_out;

endmodule
`default_nettype wire
